// File: rtl/cache_req_ctrl.sv
// cache_req_ctrl: request sequencer for one 8-way MESI cache level with per-set tree pseudo-LRU.
// Defining CACHE_STATS_EN adds saturating 32-bit hit_cnt / miss_cnt outputs.
module cache_req_ctrl #(
    parameter int WAYS     = 8,
    parameter int WAYS_REP = 3,
    parameter int TAG      = 12,
    parameter int INDEX    = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_cmd,
    input  logic [TAG-1:0]        req_tag,
    input  logic [INDEX-1:0]      req_index,
    output logic                  arr_rd_en,
    output logic [INDEX-1:0]      arr_index,
    input  logic [WAYS*TAG-1:0]   arr_rd_tag,
    input  logic [WAYS*2-1:0]     arr_rd_mesi,
    output logic                  arr_wr_en,
    output logic [WAYS_REP-1:0]   arr_wr_way,
    output logic [TAG-1:0]        arr_wr_tag,
    output logic [1:0]            arr_wr_mesi,
    output logic                  bus_valid,
    output logic [1:0]            bus_op,
    output logic [TAG-1:0]        bus_tag,
    input  logic                  bus_done,
    input  logic                  bus_shared,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [WAYS_REP-1:0]   rsp_way
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int SETS = 2 ** INDEX;
    localparam logic [1:0] MESI_I = 2'b00, MESI_S = 2'b01, MESI_E = 2'b10, MESI_M = 2'b11;
    localparam logic [1:0] CMD_WRITE = 2'b01, CMD_SNOOP = 2'b10;
    localparam logic [1:0] BUS_FILL = 2'b01, BUS_WB = 2'b10, BUS_UPG = 2'b11;

    typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WB, FILL, UPG, UPDATE, RESP} state_t;

    state_t               state_r;
    logic [1:0]           cmd_r;
    logic [TAG-1:0]       tag_r;
    logic [INDEX-1:0]     index_r;
    logic [WAYS_REP-1:0]  way_r;
    logic                 hit_r;
    logic [6:0]           plru_r [SETS];

    logic [TAG-1:0]       way_tag_s  [WAYS];
    logic [1:0]           way_mesi_s [WAYS];
    logic [WAYS-1:0]      hit_vec_s, inv_vec_s;
    logic [WAYS_REP-1:0]  hit_way_s, victim_s, touch_way_s;
    logic [1:0]           hit_mesi_s, victim_mesi_s, fill_mesi_s;
    logic [TAG-1:0]       victim_tag_s;
    logic                 hit_any_s, is_snoop_s, is_write_s, touch_en_s;

    function automatic logic [WAYS_REP-1:0] lowest_way(input logic [WAYS-1:0] v);
        logic [WAYS_REP-1:0] r;
        r = {WAYS_REP{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            r = v[w] ? w[WAYS_REP-1:0] : r;
        end
        return r;
    endfunction

    // Tree walk: each node bit points at the half holding the victim.
    function automatic logic [WAYS_REP-1:0] plru_victim(input logic [6:0] b);
        logic       b0, b1;
        logic [2:0] n;
        b0 = b[0];
        b1 = b0 ? b[2] : b[1];
        n  = 3'd3 + {1'b0, b0, b1};
        return {b0, b1, b[n]};
    endfunction

    function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [WAYS_REP-1:0] w);
        logic [6:0] r;
        r = b;
        r[0] = ~w[2];
        r[w[2] ? 3'd2 : 3'd1] = ~w[1];
        r[3'd3 + {1'b0, w[2:1]}] = ~w[0];
        return r;
    endfunction

    assign req_ready = (state_r == IDLE);

    // Tag compare, victim choice and PLRU touch decode for the set being looked up.
    always_comb begin
        is_snoop_s = (cmd_r == CMD_SNOOP);
        is_write_s = (cmd_r == CMD_WRITE);
        for (int w = 0; w < WAYS; w++) begin
            way_tag_s[w]  = arr_rd_tag[w*TAG +: TAG];
            way_mesi_s[w] = arr_rd_mesi[w*2 +: 2];
            hit_vec_s[w]  = (way_tag_s[w] == tag_r) && (way_mesi_s[w] != MESI_I);
            inv_vec_s[w]  = (way_mesi_s[w] == MESI_I);
        end
        hit_any_s     = |hit_vec_s;
        hit_way_s     = lowest_way(hit_vec_s);
        hit_mesi_s    = way_mesi_s[hit_way_s];
        victim_s      = (|inv_vec_s) ? lowest_way(inv_vec_s) : plru_victim(plru_r[index_r]);
        victim_mesi_s = way_mesi_s[victim_s];
        victim_tag_s  = way_tag_s[victim_s];
        fill_mesi_s   = is_write_s ? MESI_M : (bus_shared ? MESI_S : MESI_E);
        touch_en_s    = ((state_r == COMPARE) && !is_snoop_s && !is_write_s && hit_any_s) ||
                        ((state_r == UPDATE) && !is_snoop_s);
        touch_way_s   = (state_r == COMPARE) ? hit_way_s : way_r;
    end

    // Per-set pseudo-LRU storage.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < SETS; i++) plru_r[i] <= 7'd0;
        end else if (touch_en_s) begin
            plru_r[index_r] <= plru_touch(plru_r[index_r], touch_way_s);
        end
    end

    // Request sequencer; every output is set on the transition into the state that owns it.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r     <= IDLE;
            cmd_r       <= 2'b00;
            tag_r       <= {TAG{1'b0}};
            index_r     <= {INDEX{1'b0}};
            way_r       <= {WAYS_REP{1'b0}};
            hit_r       <= 1'b0;
            arr_rd_en   <= 1'b0;
            arr_index   <= {INDEX{1'b0}};
            arr_wr_en   <= 1'b0;
            arr_wr_way  <= {WAYS_REP{1'b0}};
            arr_wr_tag  <= {TAG{1'b0}};
            arr_wr_mesi <= 2'b00;
            bus_valid   <= 1'b0;
            bus_op      <= 2'b00;
            bus_tag     <= {TAG{1'b0}};
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_way     <= {WAYS_REP{1'b0}};
        end else begin
            arr_rd_en <= 1'b0;
            arr_wr_en <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_way   <= {WAYS_REP{1'b0}};
            case (state_r)
                IDLE: if (req_valid) begin
                    cmd_r     <= req_cmd;
                    tag_r     <= req_tag;
                    index_r   <= req_index;
                    arr_rd_en <= 1'b1;
                    arr_index <= req_index;
                    state_r   <= LOOKUP;
                end
                LOOKUP: state_r <= COMPARE;
                COMPARE: begin
                    way_r <= hit_any_s ? hit_way_s : victim_s;
                    hit_r <= hit_any_s;
                    if (hit_any_s && (is_snoop_s || is_write_s)) begin
                        if (is_snoop_s ? (hit_mesi_s == MESI_M) : (hit_mesi_s == MESI_S)) begin
                            bus_valid <= 1'b1;
                            bus_op    <= is_snoop_s ? BUS_WB : BUS_UPG;
                            bus_tag   <= tag_r;
                            state_r   <= is_snoop_s ? WB : UPG;
                        end else begin
                            arr_wr_en   <= 1'b1;
                            arr_wr_way  <= hit_way_s;
                            arr_wr_tag  <= tag_r;
                            arr_wr_mesi <= is_snoop_s ? MESI_I : MESI_M;
                            state_r     <= UPDATE;
                        end
                    end else if (hit_any_s || is_snoop_s) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= hit_any_s;
                        rsp_way   <= hit_any_s ? hit_way_s : {WAYS_REP{1'b0}};
                        state_r   <= RESP;
                    end else begin
                        bus_valid <= 1'b1;
                        bus_op    <= (victim_mesi_s == MESI_M) ? BUS_WB : BUS_FILL;
                        bus_tag   <= (victim_mesi_s == MESI_M) ? victim_tag_s : tag_r;
                        state_r   <= (victim_mesi_s == MESI_M) ? WB : FILL;
                    end
                end
                WB: if (bus_done) begin
                    bus_valid <= 1'b0;
                    bus_op    <= 2'b00;
                    bus_tag   <= {TAG{1'b0}};
                    if (is_snoop_s) begin
                        arr_wr_en   <= 1'b1;
                        arr_wr_way  <= way_r;
                        arr_wr_tag  <= tag_r;
                        arr_wr_mesi <= MESI_I;
                        state_r     <= UPDATE;
                    end else begin
                        state_r <= FILL;
                    end
                end
                // Coming from WB the fill is raised one cycle late so bus_valid dips after bus_done.
                FILL: if (!bus_valid) begin
                    bus_valid <= 1'b1;
                    bus_op    <= BUS_FILL;
                    bus_tag   <= tag_r;
                end else if (bus_done) begin
                    bus_valid   <= 1'b0;
                    bus_op      <= 2'b00;
                    bus_tag     <= {TAG{1'b0}};
                    arr_wr_en   <= 1'b1;
                    arr_wr_way  <= way_r;
                    arr_wr_tag  <= tag_r;
                    arr_wr_mesi <= fill_mesi_s;
                    state_r     <= UPDATE;
                end
                UPG: if (bus_done) begin
                    bus_valid   <= 1'b0;
                    bus_op      <= 2'b00;
                    bus_tag     <= {TAG{1'b0}};
                    arr_wr_en   <= 1'b1;
                    arr_wr_way  <= way_r;
                    arr_wr_tag  <= tag_r;
                    arr_wr_mesi <= MESI_M;
                    state_r     <= UPDATE;
                end
                UPDATE: begin
                    rsp_valid <= 1'b1;
                    rsp_hit   <= hit_r;
                    rsp_way   <= way_r;
                    state_r   <= RESP;
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters, one update per non-snoop response.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if ((state_r == RESP) && !is_snoop_s) begin
            if (rsp_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// Directed self-checking bench for cache_req_ctrl; the bench models the tag/state array and the bus.
module tb_cache_req_ctrl;
    logic        clk = 1'b0, rstb = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_cmd = 2'b00;
    logic [11:0] req_tag = 12'h000;
    logic [3:0]  req_index = 4'h0;
    logic        arr_rd_en, arr_wr_en, bus_valid, rsp_valid, rsp_hit;
    logic [3:0]  arr_index;
    logic [95:0] arr_rd_tag = 96'h0;
    logic [15:0] arr_rd_mesi = 16'h0;
    logic [2:0]  arr_wr_way, rsp_way;
    logic [11:0] arr_wr_tag, bus_tag;
    logic [1:0]  arr_wr_mesi, bus_op;
    logic        bus_done = 1'b0, bus_shared = 1'b0;

    logic [11:0] tag_m  [16][8];
    logic [1:0]  mesi_m [16][8];

    int tests = 0, fails = 0;
    int rd_cyc, wr_cnt, wr_cyc, rsp_cyc, rsp_cnt, nops, hs_err, bus_len0;
    logic [2:0]  wr_way, rsp_way_o;
    logic [11:0] wr_tag;
    logic [1:0]  wr_mesi;
    logic        rsp_hit_o;
    logic [1:0]  ops [4];
    logic [11:0] otags [4];

    always #5 clk = ~clk;

    cache_req_ctrl dut (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_tag(req_tag), .req_index(req_index), .arr_rd_en(arr_rd_en), .arr_index(arr_index),
        .arr_rd_tag(arr_rd_tag), .arr_rd_mesi(arr_rd_mesi), .arr_wr_en(arr_wr_en),
        .arr_wr_way(arr_wr_way), .arr_wr_tag(arr_wr_tag), .arr_wr_mesi(arr_wr_mesi),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_tag(bus_tag), .bus_done(bus_done),
        .bus_shared(bus_shared), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way)
    );

    task automatic set_way(input int idx, input int way, input logic [11:0] tag, input logic [1:0] mesi);
        tag_m[idx][way]  = tag;
        mesi_m[idx][way] = mesi;
    endtask

    // Issues one request, plays array and bus, and records what the controller did (cycle 1 = after accept edge).
    task automatic run_req(input logic [1:0] cmd, input logic [11:0] tag, input logic [3:0] idx,
                           input int delay, input logic shared);
        logic rd_pend, prev_bv, prev_done;
        logic [1:0] cur_op;
        logic [11:0] cur_tag;
        int bv_cnt;
        rd_cyc = -1; wr_cnt = 0; wr_cyc = -1; rsp_cyc = -1; rsp_cnt = 0; nops = 0; hs_err = 0; bus_len0 = 0;
        wr_way = 3'd0; wr_tag = 12'h000; wr_mesi = 2'b00; rsp_hit_o = 1'b0; rsp_way_o = 3'd0;
        for (int i = 0; i < 4; i++) begin ops[i] = 2'b00; otags[i] = 12'h000; end
        rd_pend = 1'b0; prev_bv = 1'b0; prev_done = 1'b0; bv_cnt = 0; cur_op = 2'b00; cur_tag = 12'h000;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = cmd; req_tag = tag; req_index = idx;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            bus_done = 1'b0;
            if (prev_done && bus_valid) hs_err++;
            if (arr_rd_en) begin
                if (rd_cyc < 0) rd_cyc = cyc;
                rd_pend = 1'b1;
            end
            if (arr_wr_en) begin
                wr_cnt++; wr_cyc = cyc; wr_way = arr_wr_way; wr_tag = arr_wr_tag; wr_mesi = arr_wr_mesi;
                tag_m[idx][arr_wr_way] = arr_wr_tag;
                mesi_m[idx][arr_wr_way] = arr_wr_mesi;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin rsp_cyc = cyc; rsp_hit_o = rsp_hit; rsp_way_o = rsp_way; end
            end
            if (bus_valid) begin
                if (!prev_bv) begin
                    if (nops < 4) begin ops[nops] = bus_op; otags[nops] = bus_tag; end
                    nops++; bv_cnt = 0; cur_op = bus_op; cur_tag = bus_tag;
                end else if (bus_op !== cur_op || bus_tag !== cur_tag) begin
                    hs_err++;
                end
                bv_cnt++;
                if (nops == 1) bus_len0 = bv_cnt;
                if (bv_cnt >= delay) begin bus_done = 1'b1; bus_shared = shared; end
            end
            prev_done = bus_done; prev_bv = bus_valid;
            if (rsp_cyc >= 0 && cyc > rsp_cyc) break;
            @(posedge clk);
            #1;
            for (int w = 0; w < 8; w++) begin
                arr_rd_tag[w*12 +: 12] = rd_pend ? tag_m[idx][w] : 12'h000;
                arr_rd_mesi[w*2 +: 2]  = rd_pend ? mesi_m[idx][w] : 2'b00;
            end
            rd_pend = 1'b0;
        end
        bus_done = 1'b0;
    endtask

    task automatic test_reset;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", req_ready); end
        tests++; if ({bus_valid, rsp_valid, arr_rd_en, arr_wr_en} !== 4'b0000) begin
            fails++; $display("FAIL rst_outs got %b exp 0000", {bus_valid, rsp_valid, arr_rd_en, arr_wr_en}); end
        @(negedge clk) rstb = 1'b1;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_post got %b exp 1", req_ready); end
    endtask

    task automatic test_read_hit;
        set_way(2, 5, 12'h123, 2'b10);
        run_req(2'b00, 12'h123, 4'd2, 1, 1'b0);
        tests++; if (rd_cyc !== 1) begin fails++; $display("FAIL rh_rd_cyc got %0d exp 1", rd_cyc); end
        tests++; if (rsp_cyc !== 3) begin fails++; $display("FAIL rh_rsp_cyc got %0d exp 3", rsp_cyc); end
        tests++; if ({rsp_hit_o, rsp_way_o} !== 4'b1101) begin fails++; $display("FAIL rh_rsp got %b exp 1101", {rsp_hit_o, rsp_way_o}); end
        tests++; if (wr_cnt + nops !== 0) begin fails++; $display("FAIL rh_no_side got %0d exp 0", wr_cnt + nops); end
        tests++; if (rsp_cnt !== 1) begin fails++; $display("FAIL rh_rsp_cnt got %0d exp 1", rsp_cnt); end
        run_req(2'b01, 12'h123, 4'd2, 1, 1'b0);
        tests++; if (wr_cyc !== 3 || rsp_cyc !== 4) begin fails++; $display("FAIL wh_lat got wr %0d rsp %0d exp 3 4", wr_cyc, rsp_cyc); end
        tests++; if ({wr_way, wr_tag, wr_mesi} !== {3'd5, 12'h123, 2'b11}) begin
            fails++; $display("FAIL wh_write got way %0d tag %h mesi %b exp 5 123 11", wr_way, wr_tag, wr_mesi); end
        tests++; if ({rsp_hit_o, rsp_way_o, nops[2:0]} !== 7'b1101000) begin
            fails++; $display("FAIL wh_rsp got hit %b way %0d ops %0d exp 1 5 0", rsp_hit_o, rsp_way_o, nops); end
        run_req(2'b11, 12'h123, 4'd2, 1, 1'b0);
        tests++; if ({rsp_hit_o, rsp_way_o} !== 4'b1101 || rsp_cyc !== 3 || wr_cnt !== 0) begin
            fails++; $display("FAIL rsv_read got hit %b way %0d cyc %0d wr %0d exp 1 5 3 0", rsp_hit_o, rsp_way_o, rsp_cyc, wr_cnt); end
    endtask

    task automatic test_write_miss;
        run_req(2'b01, 12'h0AA, 4'd0, 4, 1'b0);
        tests++; if (nops !== 1 || ops[0] !== 2'b01 || otags[0] !== 12'h0AA) begin
            fails++; $display("FAIL wm_bus got n %0d op %b tag %h exp 1 01 0aa", nops, ops[0], otags[0]); end
        tests++; if (bus_len0 !== 4 || hs_err !== 0) begin fails++; $display("FAIL wm_hs got len %0d err %0d exp 4 0", bus_len0, hs_err); end
        tests++; if (wr_cnt !== 1 || {wr_way, wr_tag, wr_mesi} !== {3'd0, 12'h0AA, 2'b11}) begin
            fails++; $display("FAIL wm_write got n %0d way %0d tag %h mesi %b exp 1 0 0aa 11", wr_cnt, wr_way, wr_tag, wr_mesi); end
        tests++; if (wr_cyc !== 7 || rsp_cyc !== 8) begin fails++; $display("FAIL wm_lat got wr %0d rsp %0d exp 7 8", wr_cyc, rsp_cyc); end
        tests++; if ({rsp_hit_o, rsp_way_o} !== 4'b0000) begin fails++; $display("FAIL wm_rsp got %b exp 0000", {rsp_hit_o, rsp_way_o}); end
    endtask

    task automatic test_plru_victim;
        for (int w = 0; w < 8; w++) set_way(6, w, 12'h100 + 12'(w), 2'b01);
        run_req(2'b00, 12'h7FF, 4'd6, 2, 1'b1);
        tests++; if (nops !== 1 || ops[0] !== 2'b01 || wr_cnt !== 1) begin
            fails++; $display("FAIL pv1_bus got n %0d op %b wr %0d exp 1 01 1", nops, ops[0], wr_cnt); end
        tests++; if ({wr_way, wr_tag, wr_mesi} !== {3'd0, 12'h7FF, 2'b01}) begin
            fails++; $display("FAIL pv1_write got way %0d tag %h mesi %b exp 0 7ff 01", wr_way, wr_tag, wr_mesi); end
        run_req(2'b00, 12'h7FE, 4'd6, 1, 1'b0);
        tests++; if ({wr_way, wr_mesi, rsp_way_o, rsp_hit_o} !== {3'd4, 2'b10, 3'd4, 1'b0}) begin
            fails++; $display("FAIL pv2_victim got way %0d mesi %b rsp %0d hit %b exp 4 10 4 0", wr_way, wr_mesi, rsp_way_o, rsp_hit_o); end
    endtask

    task automatic test_wb_victim;
        logic [11:0] ht [3];
        logic [2:0]  hw [3];
        ht[0] = 12'h202; ht[1] = 12'h200; ht[2] = 12'h204;
        hw[0] = 3'd2;    hw[1] = 3'd0;    hw[2] = 3'd4;
        for (int w = 0; w < 8; w++) set_way(5, w, 12'h200 + 12'(w), 2'b10);
        set_way(5, 3, 12'h055, 2'b11);
        for (int i = 0; i < 3; i++) begin
            run_req(2'b00, ht[i], 4'd5, 1, 1'b0);
            tests++; if ({rsp_hit_o, rsp_way_o} !== {1'b1, hw[i]}) begin
                fails++; $display("FAIL wbv_hit%0d got hit %b way %0d exp 1 %0d", i, rsp_hit_o, rsp_way_o, hw[i]); end
        end
        run_req(2'b00, 12'h3AB, 4'd5, 3, 1'b0);
        tests++; if (nops !== 2 || ops[0] !== 2'b10 || otags[0] !== 12'h055) begin
            fails++; $display("FAIL wbv_wb got n %0d op %b tag %h exp 2 10 055", nops, ops[0], otags[0]); end
        tests++; if (ops[1] !== 2'b01 || otags[1] !== 12'h3AB || hs_err !== 0) begin
            fails++; $display("FAIL wbv_fill got op %b tag %h err %0d exp 01 3ab 0", ops[1], otags[1], hs_err); end
        tests++; if (wr_cnt !== 1 || {wr_way, wr_tag, wr_mesi} !== {3'd3, 12'h3AB, 2'b10}) begin
            fails++; $display("FAIL wbv_write got n %0d way %0d tag %h mesi %b exp 1 3 3ab 10", wr_cnt, wr_way, wr_tag, wr_mesi); end
        tests++; if (rsp_cyc !== 11 || {rsp_hit_o, rsp_way_o} !== 4'b0011) begin
            fails++; $display("FAIL wbv_rsp got cyc %0d hit %b way %0d exp 11 0 3", rsp_cyc, rsp_hit_o, rsp_way_o); end
    endtask

    task automatic test_upgrade_snoop;
        set_way(7, 1, 12'h0F0, 2'b01);
        run_req(2'b01, 12'h0F0, 4'd7, 2, 1'b0);
        tests++; if (nops !== 1 || ops[0] !== 2'b11 || otags[0] !== 12'h0F0) begin
            fails++; $display("FAIL upg_bus got n %0d op %b tag %h exp 1 11 0f0", nops, ops[0], otags[0]); end
        tests++; if (wr_cnt !== 1 || {wr_way, wr_mesi, rsp_hit_o, rsp_way_o} !== {3'd1, 2'b11, 1'b1, 3'd1}) begin
            fails++; $display("FAIL upg_write got n %0d way %0d mesi %b hit %b exp 1 1 11 1", wr_cnt, wr_way, wr_mesi, rsp_hit_o); end
        run_req(2'b10, 12'h0F0, 4'd7, 2, 1'b0);
        tests++; if (nops !== 1 || ops[0] !== 2'b10 || otags[0] !== 12'h0F0) begin
            fails++; $display("FAIL snp_wb got n %0d op %b tag %h exp 1 10 0f0", nops, ops[0], otags[0]); end
        tests++; if (wr_cnt !== 1 || {wr_way, wr_mesi, rsp_hit_o, rsp_way_o} !== {3'd1, 2'b00, 1'b1, 3'd1}) begin
            fails++; $display("FAIL snp_inv got n %0d way %0d mesi %b hit %b exp 1 1 00 1", wr_cnt, wr_way, wr_mesi, rsp_hit_o); end
        run_req(2'b10, 12'h0F0, 4'd7, 2, 1'b0);
        tests++; if (rsp_cyc !== 3 || rsp_hit_o !== 1'b0 || wr_cnt !== 0 || nops !== 0) begin
            fails++; $display("FAIL snp_miss got cyc %0d hit %b wr %0d ops %0d exp 3 0 0 0", rsp_cyc, rsp_hit_o, wr_cnt, nops); end
        run_req(2'b10, 12'h204, 4'd5, 2, 1'b0);
        tests++; if (nops !== 0 || wr_cyc !== 3 || {wr_way, wr_mesi, rsp_hit_o, rsp_way_o} !== {3'd4, 2'b00, 1'b1, 3'd4}) begin
            fails++; $display("FAIL snp_clean got ops %0d wrcyc %0d way %0d mesi %b hit %b exp 0 3 4 00 1", nops, wr_cyc, wr_way, wr_mesi, rsp_hit_o); end
    endtask

    task automatic test_abort_reset;
        int found, bad;
        found = 0; bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 2'b01; req_tag = 12'h111; req_index = 4'd9;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus_valid) begin found = 1; break; end
        end
        tests++; if (found !== 1) begin fails++; $display("FAIL abort_fill got %0d exp 1", found); end
        rstb = 1'b0;
        #1;
        tests++; if ({bus_valid, req_ready, rsp_valid} !== 3'b010) begin
            fails++; $display("FAIL abort_async got %b exp 010", {bus_valid, req_ready, rsp_valid}); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid || arr_wr_en || bus_valid) bad++;
        end
        rstb = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rsp_valid || arr_wr_en || bus_valid) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL abort_quiet got %0d exp 0", bad); end
        run_req(2'b00, 12'h7FD, 4'd6, 1, 1'b1);
        tests++; if (wr_cnt !== 1 || wr_way !== 3'd0 || nops !== 1) begin
            fails++; $display("FAIL abort_plru got n %0d way %0d ops %0d exp 1 0 1", wr_cnt, wr_way, nops); end
    endtask

    initial begin
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 8; w++) set_way(s, w, 12'h000, 2'b00);
        repeat (3) @(posedge clk);
        test_reset();
        test_read_hit();
        test_write_miss();
        test_plru_victim();
        test_wb_victim();
        test_upgrade_snoop();
        test_abort_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
